// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and helpers for the UART program loader
package uart_loader_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int bytes_per_word(input int word_w);
        return word_w / UART_DATA_BITS;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with rx synchroniser
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]      bit_idx, bit_idx_next;
    logic [7:0]      shift, shift_next;
    logic            valid_next, err_next;

    // two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // receiver state and registered one-cycle result strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            byte_valid <= valid_next;
            stop_err   <= err_next;
        end
    end

    // next-state: half-bit start check, then mid-bit samples for data and stop
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_sync) state_next = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) state_next = STOP;
                    else bit_idx_next = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    valid_next = rx_sync;
                    err_next   = !rx_sync;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART to instruction-memory loader; optional UART_LOADER_CKSUM_EN adds cksum/cksum_ok
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int LSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              rx,
    input  logic              prog,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              prog_ena,
    output logic [ADDR_W:0]   word_count,
    output logic              frame_err,
    output logic              overflow
`ifdef UART_LOADER_CKSUM_EN
    ,
    output logic [7:0]        cksum,
    output logic              cksum_ok
`endif
);

    localparam int BPW = bytes_per_word(WORD_W);
    localparam logic [3:0] LAST_IDX = 4'(BPW - 1);

    logic              byte_valid, stop_err;
    logic [7:0]        byte_data;
    logic [3:0]        byte_idx;
    logic [WORD_W-1:0] asm_q, asm_next;
    logic              rise, fall, active;
    int                lane;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (Rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err)
    );

    // prog_ena is prog delayed by one cycle, so it doubles as the edge-detect history
    assign rise   = prog & ~prog_ena;
    assign fall   = ~prog & prog_ena;
    assign active = prog & prog_ena;

    // place the incoming byte into its lane of the partially assembled word
    always_comb begin
        asm_next = asm_q;
        lane     = (LSB_FIRST != 0) ? int'(byte_idx) : (BPW - 1 - int'(byte_idx));
        for (int k = 0; k < BPW; k++) begin
            if (k == lane) asm_next[k*8 +: 8] = byte_data;
        end
    end

    // session control, word assembly, write strobe, address counter and flags
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            prog_ena   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            byte_idx   <= '0;
            asm_q      <= '0;
        end else begin
            prog_ena <= prog;
            mem_we   <= 1'b0;
            // a strobe already issued always advances, even across prog falling
            if (mem_we) begin
                mem_addr   <= mem_addr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W+1)'(1);
            end
            if (rise) begin
                mem_addr   <= '0;
                word_count <= '0;
                byte_idx   <= '0;
                frame_err  <= 1'b0;
                overflow   <= 1'b0;
            end else if (!active) begin
                byte_idx <= '0;
            end else begin
                if (stop_err) frame_err <= 1'b1;
                if (byte_valid) begin
                    if (byte_idx == LAST_IDX) begin
                        byte_idx <= '0;
                        if (word_count[ADDR_W]) begin
                            overflow <= 1'b1;
                        end else begin
                            mem_wdata <= asm_next;
                            mem_we    <= 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 4'd1;
                        asm_q    <= asm_next;
                    end
                end
            end
        end
    end

`ifdef UART_LOADER_CKSUM_EN
    // running byte sum; a session is good when the host trailer brings it to zero
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            cksum    <= '0;
            cksum_ok <= 1'b0;
        end else if (rise) begin
            cksum    <= '0;
            cksum_ok <= 1'b0;
        end else begin
            if (active && byte_valid) cksum <= cksum + byte_data;
            if (fall) cksum_ok <= (cksum == 8'd0);
        end
    end
`endif

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Parametrised successor to the core's fixed UART programmer.
- Receives 8N1 UART bytes on rx and assembles them into WORD_W-bit words, with configurable byte order.
- Writes each completed word to instruction memory through a simple write port at an auto-incrementing address.
- Sits between the board rx pin and the fetch stage's memory controller. The core drives prog; the loader drives prog_ena, which stalls the pipeline.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- WORD_W, 32, memory word width; multiple of 8, 8..64.
- ADDR_W, 10, word-address width of the target memory.
- LSB_FIRST, 1, 1 = first received byte lands in bits [7:0]; 0 = first byte lands in the MSB.

Ports:
- clk  in  1  system clock
- Rst  in  1  asynchronous, active-low reset (0 = reset)
- rx  in  1  UART receive line, idles high, asynchronous to clk
- prog  in  1  load-session enable, level
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  assembled word
- prog_ena  out  1  high while a session is active; drives the memory-controller mux
- word_count  out  ADDR_W+1  words written this session
- frame_err  out  1  sticky; a stop bit sampled low
- overflow  out  1  sticky; more words arrived than 2^ADDR_W

Behaviour:
- Reset (Rst=0, async): all outputs 0, rx FSM in IDLE, byte index 0, rx synchroniser preset to 1.
- rx synchronisation: 2-flop synchroniser; all decoding uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised falling edge.
  - START: count CLKS_PER_BIT/2. If rx is high at that point it is a false start -> IDLE. Otherwise -> DATA.
  - DATA: sample 8 bits LSB-first, each CLKS_PER_BIT after the previous sample (mid-bit).
  - STOP: sample one bit-time later. High -> byte_valid pulses for one cycle, then IDLE. Low -> frame_err set, byte discarded, then IDLE.
  - No re-arm delay after STOP; a back-to-back start bit is detected.
- Session control:
  - Rising edge of prog: mem_addr=0, word_count=0, byte index=0, frame_err=0, overflow=0; prog_ena goes high the next cycle.
  - prog low: byte_valid is ignored; the RX FSM keeps running but its results are dropped.
  - Falling edge of prog: prog_ena drops the next cycle and any partial word is discarded.
  - A write strobe coincident with the falling edge still completes.
- Word assembly:
  - Byte k of a word, k = 0..WORD_W/8-1, goes to lane k when LSB_FIRST=1, or lane (WORD_W/8-1-k) when LSB_FIRST=0.
  - On the last byte's byte_valid cycle the word register loads. The next cycle mem_we=1 with stable mem_addr/mem_wdata.
  - The cycle after that, mem_addr increments and word_count increments.
  - Latency from the stop-bit sample to mem_we is 2 cycles.
- Address wrap:
  - When word_count reaches 2^ADDR_W, further completed words set overflow and produce no mem_we.
  - mem_addr holds at its wrapped value 0 and is never rewritten.
- mem_wdata holds the last written word between strobes.
- Reset mid-byte or mid-word: everything clears immediately; the next session restarts at address 0.

Optional Feature:
- Macro: UART_LOADER_CKSUM_EN.
- Defined:
  - Adds output cksum [7:0]: modulo-256 sum of every accepted byte this session, cleared on the rising edge of prog.
  - Adds output cksum_ok: 1 when cksum==0 after prog falls, so the host appends a two's-complement trailer byte.
  - cksum_ok holds until the next session.
  - The trailer byte is still counted toward word assembly.
- Undefined: neither port exists; no adder logic.

Decomposition:
- Package uart_loader_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP).
  - UART_DATA_BITS=8.
  - Function bytes_per_word(WORD_W).
- Sub-module uart_rx_byte: synchroniser, RX FSM and bit counter, parametrised by CLKS_PER_BIT. Outputs byte_valid, byte_data, stop_err.
- Top level: session control, word assembler, address counter and flags.

Test Plan:
- LSB_FIRST=1, prog=1, send 0x13,0x00,0x00,0x00 -> one mem_we at addr 0, wdata 0x00000013, word_count=1; mem_we 2 cycles after the stop-bit sample.
- LSB_FIRST=0, send 0xDE,0xAD,0xBE,0xEF -> wdata 0xDEADBEEF at addr 0; a second word goes to addr 1.
- 1/4-bit low glitch on rx -> no byte; FSM back in IDLE; no mem_we.
- Byte sent with stop bit low -> frame_err=1, no lane update; cleared by the next prog rising edge.
- ADDR_W=2, send 5 words -> 4 writes at addr 0..3, 5th sets overflow=1 with no mem_we; Rst=0 mid-6th byte clears all outputs to 0.
- With UART_LOADER_CKSUM_EN: send 0x01,0x02,0x03,0xFA then drop prog -> cksum=0x00, cksum_ok=1.
